// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller burst generators (read and write side).
package dmac_pkg;

  localparam int unsigned BEAT_BYTES            = 4;
  localparam int unsigned PAGE_BYTES            = 4096;
  localparam int unsigned DEFAULT_MAX_BURST_LEN = 16;

  // Burst generator FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Beats in the next burst: the smallest of the remaining beats, the burst cap and
  // the beats left before the next 4 KB page. word_off is the address bits [11:2].
  // Callers guarantee remaining != 0 and max_len <= 16, so the result fits in 5 bits.
  function automatic logic [4:0] burst_beats(input logic [9:0]  word_off,
                                             input logic [31:0] remaining,
                                             input logic [4:0]  max_len);
    logic [10:0] page_beats;
    logic [31:0] beats;
    page_beats = 11'd1024 - {1'b0, word_off};
    beats      = remaining;
    if ({21'd0, page_beats} < beats) beats = {21'd0, page_beats};
    if ({27'd0, max_len} < beats)    beats = {27'd0, max_len};
    return beats[4:0];
  endfunction

endpackage

// File: rtl/dmac_burst_gen.sv
// Read-side burst request generator: splits one descriptor into AXI-legal bursts
// (capped length, no 4 KB crossing) presented one at a time on a valid/ready port.
module dmac_burst_gen
  import dmac_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int BYTE_CNT_WIDTH = 16,
  parameter int MAX_BURST_LEN  = DEFAULT_MAX_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     src_addr_i,
  input  logic [BYTE_CNT_WIDTH-1:0] byte_len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [ADDR_WIDTH-1:0]     req_addr_o,
  output logic [3:0]                req_len_o
);

  // Remaining work is counted in 4-byte beats
  localparam int RW = BYTE_CNT_WIDTH - 2;
  localparam logic [4:0] MAX_LEN = 5'(MAX_BURST_LEN);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [RW-1:0]         rem_reg, rem_next;
  logic [3:0]            len_reg, len_next;
  logic                  valid_reg, valid_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;

  logic [ADDR_WIDTH-1:0] start_addr;
  logic [RW-1:0]         start_rem;
  logic [4:0]            start_beats;
  logic [4:0]            cur_beats;
  logic [ADDR_WIDTH-1:0] step_addr;
  logic [RW-1:0]         step_rem;
  logic [4:0]            step_beats;

  // Sub-word address and length bits are ignored by design
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, src_addr_i[1:0], byte_len_i[1:0]};

  // Descriptor decode and first-burst sizing
  assign start_addr  = {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign start_rem   = byte_len_i[BYTE_CNT_WIDTH-1:2];
  assign start_beats = burst_beats(start_addr[11:2], 32'(start_rem), MAX_LEN);

  // Post-handshake position and the size of the burst that follows it
  assign cur_beats  = {1'b0, len_reg} + 5'd1;
  assign step_addr  = addr_reg + ADDR_WIDTH'({cur_beats, 2'b00});
  assign step_rem   = rem_reg - RW'(cur_beats);
  assign step_beats = burst_beats(step_addr[11:2], 32'(step_rem), MAX_LEN);

  // FSM next-state and datapath update
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    len_next   = len_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    busy_next  = busy_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          busy_next = 1'b1;
          if (start_rem != '0) begin
            addr_next  = start_addr;
            rem_next   = start_rem;
            len_next   = 4'(start_beats - 5'd1);
            valid_next = 1'b1;
            state_next = S_REQ;
          end else begin
            // Zero-length descriptor completes without issuing a request
            done_next  = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (req_ready_i) begin
          addr_next = step_addr;
          rem_next  = step_rem;
          if (step_rem == '0) begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            // Next burst is registered now, so valid stays high with no bubble
            len_next = 4'(step_beats - 5'd1);
          end
        end
      end
      S_DONE: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: begin
        valid_next = 1'b0;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      len_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      len_reg   <= len_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign req_valid_o = valid_reg;
  assign req_addr_o  = addr_reg;
  assign req_len_o   = len_reg;
  assign done_o      = done_reg;
  assign busy_o      = busy_reg;

endmodule

// File: tb/tb_dmac_burst_gen.sv
// Directed bench for dmac_burst_gen with hand-computed burst sequences.
module tb_dmac_burst_gen;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [15:0] byte_len_i;
  logic        busy_o;
  logic        done_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic [3:0]  req_len_o;

  int tests;
  int fails;

  dmac_burst_gen #(
    .ADDR_WIDTH(32),
    .BYTE_CNT_WIDTH(16),
    .MAX_BURST_LEN(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .src_addr_i(src_addr_i),
    .byte_len_i(byte_len_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o),
    .req_len_o(req_len_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check a presented burst request
  task automatic chk_req(input string tag, input logic [31:0] a, input logic [3:0] l);
    chk({tag, ".valid"}, req_valid_o, 1'b1);
    chk({tag, ".addr"}, req_addr_o, a);
    chk({tag, ".len"}, req_len_o, l);
    chk({tag, ".busy"}, busy_o, 1'b1);
    chk({tag, ".done"}, done_o, 1'b0);
    $display("[TB] %s addr=%08h len=%0d", tag, req_addr_o, req_len_o);
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] l);
    start_i    = 1'b1;
    src_addr_i = a;
    byte_len_i = l;
    tick();
    start_i    = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    src_addr_i  = '0;
    byte_len_i  = '0;
    req_ready_i = 1'b0;

    // Reset state
    #12;
    chk("rst.valid", req_valid_o, 1'b0);
    chk("rst.done", done_o, 1'b0);
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.addr", req_addr_o, 32'h0);
    chk("rst.len", req_len_o, 4'h0);
    $display("[TB] reset state checked");
    rst_n = 1'b1;
    tick();
    tick();

    // Single burst: 64 bytes at 0x1000 -> (0x1000, 15)
    do_start(32'h1000, 16'd64);
    chk_req("single", 32'h1000, 4'd15);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    chk("single.done", done_o, 1'b1);
    chk("single.valid_off", req_valid_o, 1'b0);
    chk("single.busy_done", busy_o, 1'b1);
    tick();
    chk("single.done_clr", done_o, 1'b0);
    chk("single.busy_clr", busy_o, 1'b0);
    $display("[TB] single burst complete");

    // Length split: 100 bytes at 0x1000 -> (0x1000,15) then (0x1040,8)
    req_ready_i = 1'b1;
    do_start(32'h1000, 16'd100);
    chk_req("split1", 32'h1000, 4'd15);
    tick();
    chk_req("split2", 32'h1040, 4'd8);
    tick();
    chk("split.done", done_o, 1'b1);
    chk("split.valid_off", req_valid_o, 1'b0);
    tick();
    chk("split.done_clr", done_o, 1'b0);
    chk("split.busy_clr", busy_o, 1'b0);

    // 4 KB crossing: 64 bytes at 0x1FF0 -> (0x1FF0,3) then (0x2000,11)
    do_start(32'h1FF0, 16'd64);
    chk_req("cross1", 32'h1FF0, 4'd3);
    tick();
    chk_req("cross2", 32'h2000, 4'd11);
    tick();
    chk("cross.done", done_o, 1'b1);
    tick();
    req_ready_i = 1'b0;

    // Backpressure: 128 bytes at 0x3000, ready low for 5 cycles, stray starts ignored
    do_start(32'h3000, 16'd128);
    for (int i = 0; i < 5; i++) begin
      chk_req($sformatf("bp.hold%0d", i), 32'h3000, 4'd15);
      start_i    = (i == 1 || i == 3);
      src_addr_i = 32'h8000;
      byte_len_i = 16'd4;
      tick();
    end
    start_i = 1'b0;
    chk_req("bp.held", 32'h3000, 4'd15);
    req_ready_i = 1'b1;
    tick();
    chk_req("bp2", 32'h3040, 4'd15);
    tick();
    req_ready_i = 1'b0;
    chk("bp.done", done_o, 1'b1);
    tick();
    chk("bp.idle_valid", req_valid_o, 1'b0);
    chk("bp.idle_busy", busy_o, 1'b0);
    tick();
    chk("bp.no_stray", req_valid_o, 1'b0);

    // Zero length: done at N+1 and no request
    do_start(32'h5000, 16'd0);
    chk("zero.done", done_o, 1'b1);
    chk("zero.valid", req_valid_o, 1'b0);
    chk("zero.busy", busy_o, 1'b1);
    tick();
    chk("zero.done_clr", done_o, 1'b0);
    chk("zero.valid2", req_valid_o, 1'b0);
    chk("zero.busy_clr", busy_o, 1'b0);
    $display("[TB] zero-length transfer complete");

    // Reset during second burst of a 1024-byte transfer
    req_ready_i = 1'b1;
    do_start(32'h4000, 16'd1024);
    chk_req("rstmid1", 32'h4000, 4'd15);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    chk_req("rstmid2", 32'h4040, 4'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid", req_valid_o, 1'b0);
    chk("rstmid.addr", req_addr_o, 32'h0);
    chk("rstmid.len", req_len_o, 4'h0);
    chk("rstmid.busy", busy_o, 1'b0);
    chk("rstmid.done", done_o, 1'b0);
    tick();
    chk("rstmid.done_hold", done_o, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rstmid.after_done", done_o, 1'b0);
    chk("rstmid.after_valid", req_valid_o, 1'b0);

    // New transfer after reset: 16 bytes at 0x5000 -> (0x5000,3)
    do_start(32'h5000, 16'd16);
    chk_req("post", 32'h5000, 4'd3);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    chk("post.done", done_o, 1'b1);
    tick();
    chk("post.busy_clr", busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmac_burst_gen.md
# dmac_burst_gen

Per-channel burst request generator for the DMA controller. It sits directly upstream of the channel arbiter. It takes one transfer descriptor (source address, byte length) and splits it into AXI-legal read bursts. Each burst is at most MAX_BURST_LEN beats and never crosses a 4 KB boundary. Bursts are presented one at a time on a valid/ready request port that feeds one arbiter input.

## Interface
- ADDR_WIDTH, 32, byte address width
- BYTE_CNT_WIDTH, 16, transfer length field width (bytes)
- MAX_BURST_LEN, 16, maximum beats per burst (power of two, ≤16)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start_i  input  1  one-cycle descriptor strobe; sampled only in S_IDLE
- src_addr_i  input  ADDR_WIDTH  transfer start address; bits [1:0] ignored (treated 0)
- byte_len_i  input  BYTE_CNT_WIDTH  transfer length in bytes; bits [1:0] ignored
- busy_o  output  1  high from the cycle after an accepted start until done_o
- done_o  output  1  one-cycle pulse, transfer complete
- req_valid_o  output  1  burst request valid
- req_ready_i  input  1  arbiter accepts request
- req_addr_o  output  ADDR_WIDTH  burst start address
- req_len_o  output  4  AXI burst length, beats−1

## Operation
- Beat is 4 bytes. Remaining work is tracked in beats: remaining = byte_len_i[BYTE_CNT_WIDTH-1:2].
- Burst size = min(remaining, MAX_BURST_LEN, (4096 − addr[11:0]) >> 2).
- States: S_IDLE, S_REQ, S_DONE.
- S_IDLE:
  - start_i with remaining ≠ 0: latch the address, compute the first burst, go to S_REQ.
  - start_i with remaining = 0: go to S_DONE; no request is ever issued.
- S_REQ: req_valid_o = 1. On a req_valid_o & req_ready_i handshake:
  - addr += beats×4 and remaining −= beats.
  - If the new remaining = 0: go to S_DONE.
  - Otherwise compute and register the next burst and stay in S_REQ. valid stays high, so there is no bubble between bursts.
- S_DONE: done_o = 1 for exactly one cycle, then go to S_IDLE.
- start_i outside S_IDLE is ignored; the in-flight descriptor is unaffected.
- All outputs are registered, with no combinational path from req_ready_i to any output.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; callers must not rely on it.

## Timing
- Reset (async assert): state S_IDLE; req_valid_o, done_o and busy_o all 0; req_addr_o and req_len_o are 0.
- A reset asserted mid-transfer aborts it with no done_o pulse. Registers are released synchronously on the first clk after rst_n rises.
- Start latency: start_i sampled at edge N gives req_valid_o = 1 from cycle N+1.
- Handshake:
  - Once req_valid_o is high, req_addr_o and req_len_o hold stable until the handshake.
  - req_valid_o never drops without a handshake.
- The next burst appears in the cycle after the handshake.
- Last handshake at edge M gives done_o = 1 in cycle M+1 and busy_o = 0 from M+2.
- A new start_i is accepted from M+2 onward.
- Zero-length transfer: start at edge N gives done_o in cycle N+1.
- Throughput: one burst per cycle under continuous req_ready_i.

## Structure
- Shared package dmac_pkg holds:
  - BEAT_BYTES = 4
  - PAGE_BYTES = 4096
  - default MAX_BURST_LEN
  - a state typedef (S_IDLE, S_REQ, S_DONE)
  - a burst-size function (addr, remaining) → beats, reused by the write-side generator
- No sub-module: one FSM plus address/remaining registers.
- The wrapper packs {req_addr_o, req_len_o} into the arbiter's DATA_SIZE payload.

## Test plan
- Single burst: addr 0x1000, len 64 → one request (0x1000, len 15), then done_o one cycle after the handshake.
- Length split: addr 0x1000, len 100 → (0x1000, 15) then (0x1040, 8), back-to-back with req_ready_i held high.
- 4 KB crossing: addr 0x1FF0, len 64 → (0x1FF0, 3) then (0x2000, 11).
- Backpressure: req_ready_i low for 5 cycles → req_valid_o held, addr/len unchanged, and start_i pulses in that window are ignored.
- Zero length: len 0 → req_valid_o never asserts, done_o pulses at N+1.
- Reset mid-transfer: assert rst_n = 0 during the second burst of a 1024-byte transfer → outputs clear immediately, no done_o. A new start afterwards behaves normally.
